// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU execute stage, DMA/loader) for the byte-sliced data memory.
// Optional macro DMEM_ARB_CPU_PRIO_EN: CPU wins IDLE ties and cuts DMA bursts short.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic [3:0]    dma_we_n,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_last,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wren_n,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state_dbg,
  output logic [3:0]    beat_cnt_dbg,
  output logic          last_owner_dbg
);

  // Handshake: a requester holds req/addr/we_n/wdata stable until it sees gnt;
  // the cycle with gnt high is the beat, and a read beat returns rvalid one cycle later.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_t     state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic [3:0] beat_cnt_inc;
  logic       cpu_beat, dma_beat;
  logic       cpu_rd_beat, dma_rd_beat;
  logic       dma_release;
  logic       cpu_prio;
  logic [DW-1:0] rdata_q;

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign cpu_prio = 1'b1;
`else
  assign cpu_prio = 1'b0;
`endif

  assign cpu_beat    = (state == OWN_CPU) & cpu_req;
  assign dma_beat    = (state == OWN_DMA) & dma_req;
  assign cpu_gnt     = cpu_beat;
  assign dma_gnt     = dma_beat;
  assign cpu_rd_beat = cpu_beat & (cpu_we_n == 4'b1111);
  assign dma_rd_beat = dma_beat & (dma_we_n == 4'b1111);

  assign beat_cnt_inc = beat_cnt + 4'd1;
  // With CPU priority, a pending CPU request ends the burst after the current beat.
  assign dma_release  = (dma_beat & dma_last)
                      | (dma_beat & (beat_cnt_inc == BURST_LIM))
                      | ~dma_req
                      | (cpu_prio & cpu_req);

  always_ff @(posedge clk) begin
    if (rstd) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req)
          state_nxt = (cpu_prio || last_owner) ? OWN_CPU : OWN_DMA;
        else if (cpu_req)
          state_nxt = OWN_CPU;
        else if (dma_req)
          state_nxt = OWN_DMA;
      end
      OWN_CPU: begin
        last_owner_nxt = 1'b0;
        if (dma_req)      state_nxt = OWN_DMA;
        else if (cpu_req) state_nxt = OWN_CPU;
        else              state_nxt = IDLE;
      end
      OWN_DMA: begin
        if (dma_release) begin
          beat_cnt_nxt   = 4'd0;
          last_owner_nxt = 1'b1;
          if (cpu_req)      state_nxt = OWN_CPU;
          else if (dma_req) state_nxt = OWN_DMA;
          else              state_nxt = IDLE;
        end else if (dma_beat) begin
          beat_cnt_nxt = beat_cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outside a beat the bus parks on the last owner's inputs with writes disabled.
  always_comb begin
    mem_wren_n = 4'b1111;
    mem_addr   = last_owner ? dma_addr  : cpu_addr;
    mem_wdata  = last_owner ? dma_wdata : cpu_wdata;
    if (cpu_beat) begin
      mem_wren_n = cpu_we_n;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
    end else if (dma_beat) begin
      mem_wren_n = dma_we_n;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rstd) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cpu_rvalid <= cpu_rd_beat;
      dma_rvalid <= dma_rd_beat;
      if (cpu_rd_beat || dma_rd_beat)
        rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata      = rdata_q;
  assign dma_rdata      = rdata_q;
  assign state_dbg      = state;
  assign beat_cnt_dbg   = beat_cnt;
  assign last_owner_dbg = last_owner;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-sliced data memory (four 8-bit banks, active-low per-byte write enables) between two requesters: the CPU execute stage and a DMA/loader port.
- Owner-based FSM. Round-robin on ties. DMA bursts are bounded.
- Drives the memory address, write data and active-low byte enables, and registers read data back to the owning requester.
- Sits between the execute stage / DMA engine and the four data_mem bank instances.

Parameters:
- AW, 8, word address width; memory depth is 2^AW words.
- DW, 32, data width; four byte lanes.
- BURST_MAX, 4, maximum DMA beats per grant (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstd  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU requests one access this cycle.
- cpu_we_n  in  4  CPU byte write enables, active-low; 4'b1111 means read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DW  CPU read data.
- dma_req, dma_we_n, dma_addr, dma_wdata  in  1/4/AW/DW  DMA equivalents of the CPU inputs.
- dma_last  in  1  current DMA beat ends the burst.
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DW  DMA equivalents of the CPU outputs.
- mem_addr  out  AW  to bank address.
- mem_wdata  out  DW  to bank write data.
- mem_wren_n  out  4  per-bank write enable, active-low.
- mem_rdata  in  DW  combinational read data from the banks.

Behaviour:
- FSM states: IDLE, OWN_CPU, OWN_DMA.
- Registers: state, last_owner (0=CPU, 1=DMA), beat_cnt (4 bits), cpu_rvalid, dma_rvalid, rdata_q.
- Reset values: state=IDLE, last_owner=1, beat_cnt=0, both rvalid=0, rdata_q=0. Reset wins over every other event, including a grant or beat in progress.
- Grants are combinational from the registered state:
  - cpu_gnt = (state==OWN_CPU) & cpu_req.
  - dma_gnt = (state==OWN_DMA) & dma_req.
- A beat is a cycle in which gnt is high.
- Memory mux:
  - During a beat, mem_addr, mem_wdata and mem_wren_n come from the owner.
  - Otherwise mem_wren_n=4'b1111, and mem_addr/mem_wdata hold the last owner's inputs.
  - No write ever occurs without a gnt.
- Read return:
  - A read beat (we_n==4'b1111) samples mem_rdata into rdata_q at that edge.
  - The owner's rvalid is high for exactly the next cycle; latency is 1.
  - A write beat produces no rvalid.
  - A partial write (e.g. we_n=4'b1100) updates only banks 0-1.
- IDLE:
  - Only cpu_req: go to OWN_CPU. Only dma_req: go to OWN_DMA.
  - Both: grant the requester not equal to last_owner. Neither: stay in IDLE.
- OWN_CPU:
  - Single-beat ownership. After a beat, or when cpu_req is low, set last_owner=0.
  - Next state: OWN_DMA if dma_req, else OWN_CPU if cpu_req, else IDLE.
- OWN_DMA:
  - beat_cnt increments on each beat.
  - Release when any of: (beat & dma_last); beat_cnt reaches BURST_MAX on a beat; dma_req is low.
  - On release: beat_cnt=0, last_owner=1. Next state: OWN_CPU if cpu_req, else OWN_DMA if dma_req (new burst), else IDLE.
- The owner switch costs no bubble cycle. The first cycle of a new ownership can already carry a beat.
- A requester must hold req, addr, we_n and wdata stable until it sees gnt.
- cpu_rdata and dma_rdata both equal rdata_q. Each is qualified only by its own rvalid.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined:
  - CPU wins every tie in IDLE.
  - An OWN_DMA burst is cut after the current beat whenever cpu_req is high; next state is OWN_CPU.
  - DMA resumes afterwards with beat_cnt cleared.
- Undefined: round-robin and non-preemptive bursts exactly as above.

Test Plan:
- Reset, then CPU write addr 8'h10, wdata 32'hDEADBEEF, we_n 4'b0000; then read 8'h10 -> cpu_gnt in the cycle after the request, cpu_rvalid one cycle after the read beat, cpu_rdata=32'hDEADBEEF, dma_rvalid stays 0.
- Partial write: CPU writes 8'h20 full 32'h11223344, then we_n 4'b1100 data 32'hAABBCCDD, then reads -> 32'h1122CCDD.
- Both req from IDLE after reset -> CPU owns first (last_owner=1). Both held for 6 cycles -> ownership alternates CPU, DMA, CPU.
- DMA burst of 6 reads with dma_last never set, BURST_MAX=4 -> exactly 4 dma_gnt beats, release, re-grant, remaining 2 beats; mem_wren_n stays 4'b1111 throughout.
- DMA burst in progress, cpu_req raised on beat 2: without macro, the CPU waits until beat 4 or dma_last; with DMEM_ARB_CPU_PRIO_EN, cpu_gnt arrives the cycle after beat 2.
- rstd asserted for one cycle mid-DMA burst on beat 3 -> next cycle state=IDLE, all gnt and rvalid 0, no memory write. After rstd drops with only dma_req high, the burst restarts at beat_cnt=0.
